// File: rtl/edsac_ctl_pkg.sv
// Shared timing constants and types for the EDSAC serial order-control stages.
package edsac_ctl_pkg;

  localparam int DIGITS_PER_MINOR = 18;
  localparam int FUNC_LSB         = 12;
  localparam int FUNC_WIDTH       = 5;

  localparam logic [4:0] DIGIT_LAST = 5'(DIGITS_PER_MINOR - 1);
  localparam logic [4:0] FUNC_FIRST = 5'(FUNC_LSB);
  localparam logic [4:0] FUNC_LAST  = 5'(FUNC_LSB + FUNC_WIDTH - 1);

  typedef logic [FUNC_WIDTH-1:0] func_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMMIT  = 2'd2
  } ofr_state_t;

endpackage

// File: rtl/edsac_digit_counter.sv
// Strobe-qualified mod-18 digit counter with minor_start resync and framing check.
module edsac_digit_counter
  import edsac_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_strobe,
  input  logic       i_minor_start,
  output logic [4:0] o_digit,
  output logic       o_frame_evt,
  output logic       o_frame_err
);

  logic [4:0] r_count;
  logic       r_synced;
  logic       r_frame_err;
  logic       w_at_last;

  assign w_at_last = (r_count == DIGIT_LAST);

  // o_digit is the position of the digit being strobed right now, not the previous one.
  assign o_digit     = (i_minor_start || w_at_last) ? 5'd0 : r_count + 5'd1;
  // Until the first minor_start since reset, misalignment is not an error.
  assign o_frame_evt = i_strobe && r_synced && (i_minor_start ? !w_at_last : w_at_last);
  assign o_frame_err = r_frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= 5'd0;
      r_synced    <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (i_strobe) begin
      r_count <= o_digit;
      if (i_minor_start) r_synced <= 1'b1;
      if (o_frame_evt) r_frame_err <= 1'b1;
    end
  end

endmodule

// File: rtl/order_function_register.sv
// Captures the serial 5-bit function field of an order and holds it as registered pos/neg rails.
module order_function_register
  import edsac_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_strobe,
  input  logic       minor_start,
  input  logic       order_bit,
  input  logic       transfer_en,
  input  logic       clear,
  output logic       f11_pos,
  output logic       f12_pos,
  output logic       f13_pos,
  output logic       f14_pos,
  output logic       f15_pos,
  output logic       f11_neg,
  output logic       f12_neg,
  output logic       f13_neg,
  output logic       f14_neg,
  output logic       f15_neg,
  output logic       o_dy_2,
  output logic       order_valid,
  output logic       frame_err,
  output logic [1:0] o_dbg_state
);

  ofr_state_t r_state;
  func_t      r_shift;
  func_t      r_held;
  func_t      r_held_n;
  logic       r_dy_2;
  logic [4:0] w_digit;
  logic       w_frame_evt;
  logic       w_in_window;
  logic       w_start;

  edsac_digit_counter u_counter (
    .clk          (clk),
    .rst          (rst),
    .i_strobe     (digit_strobe),
    .i_minor_start(minor_start),
    .o_digit      (w_digit),
    .o_frame_evt  (w_frame_evt),
    .o_frame_err  (frame_err)
  );

  assign w_in_window = (w_digit >= FUNC_FIRST) && (w_digit <= FUNC_LAST);
  assign w_start     = digit_strobe && minor_start && transfer_en && !w_frame_evt;

  // order_valid: one-clk pulse in the COMMIT clk, no back-pressure; the new held
  // value is visible on the rails from the following clk. clear in that clk cancels it.
  assign order_valid = (r_state == ST_COMMIT) && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_held   <= '0;
      r_held_n <= '1;
      r_dy_2   <= 1'b0;
    end else if (clear) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_held   <= '0;
      r_held_n <= '1;
      r_dy_2   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_CAPTURE;
            r_shift <= '0;
          end
        end
        ST_CAPTURE: begin
          if (digit_strobe) begin
            if (w_frame_evt || !transfer_en) begin
              r_state <= ST_IDLE;
            end else begin
              if (w_in_window) r_shift <= {order_bit, r_shift[FUNC_WIDTH-1:1]};
              if (w_digit == DIGIT_LAST) r_state <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          r_held   <= r_shift;
          r_held_n <= ~r_shift;
          r_dy_2   <= 1'b1;
          // A minor cycle may begin in the very clk of the commit.
          if (w_start) begin
            r_state <= ST_CAPTURE;
            r_shift <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign {f15_pos, f14_pos, f13_pos, f12_pos, f11_pos} = r_held;
  assign {f15_neg, f14_neg, f13_neg, f12_neg, f11_neg} = r_held_n;
  assign o_dy_2      = r_dy_2;
  assign o_dbg_state = r_state;

endmodule
